// File: rtl/pc_call_stack_pkg.sv
// Shared definitions for the program counter with hardware call/return stack:
// default address width, mcu call/return opcodes and the command priority decode.
package pc_call_stack_pkg;

    localparam int INST_DEPTH = 8;
    localparam int PC_ADDR_W  = INST_DEPTH;

    localparam logic [3:0] MCU_CALL = 4'hC;
    localparam logic [3:0] MCU_RET  = 4'hD;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_COUNT = 3'd1,
        CMD_LOAD  = 3'd2,
        CMD_CALL  = 3'd3,
        CMD_RET   = 3'd4
    } pc_cmd_e;

    // Fixed priority ret > call > load > count; lower-priority requests are dropped.
    function automatic pc_cmd_e decode_cmd(
        input logic ret,
        input logic call,
        input logic load,
        input logic count
    );
        pc_cmd_e cmd;
        cmd = CMD_NONE;
        if (ret) begin
            cmd = CMD_RET;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (count) begin
            cmd = CMD_COUNT;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pc_call_stack_ret_stack.sv
// Return-address LIFO for pc_call_stack: storage array, occupancy pointer and
// sticky overflow/underflow flags. Entries are only ever read at sp-1.
module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_overflow;
    logic              r_underflow;

    logic [SP_W-1:0]   w_sp_dec;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_full;
    logic              w_empty;

    assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty  = (r_sp == '0);
    assign w_sp_dec = r_sp - SP_W'(1);
    // Writes happen only when not full, so sp < STACK_DEPTH and fits the index width.
    assign w_wr_idx = r_sp[IDX_W-1:0];
    assign w_rd_idx = w_sp_dec[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (push) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_sp <= r_sp + SP_W'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_sp <= w_sp_dec;
            end
        end
    end

    // Storage carries no reset; a push while full is discarded so no entry is overwritten.
    always_ff @(posedge clk) begin
        if (!rst && push && !w_full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    assign dout      = r_mem[w_rd_idx];
    assign sp        = r_sp;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with count/load and a hardware CALL/RET return-address stack.
// Optional macro PC_REL_JUMP_EN adds port rel for PC-relative loads.
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              count,
    input  logic                              load,
    input  logic                              call,
    input  logic                              ret,
`ifdef PC_REL_JUMP_EN
    input  logic                              rel,
`endif
    input  logic [ADDR_W-1:0]                 addr_in,
    output logic [ADDR_W-1:0]                 addr_out,
    output logic [$clog2(STACK_DEPTH):0]      sp,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    pc_cmd_e            w_cmd;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_inc;
    logic [ADDR_W-1:0]  w_load_target;
    logic [ADDR_W-1:0]  w_stack_top;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    assign w_cmd  = decode_cmd(ret, call, load, count);
    assign w_push = (w_cmd == CMD_CALL);
    assign w_pop  = (w_cmd == CMD_RET);
    assign w_inc  = r_addr + ADDR_W'(1);

`ifdef PC_REL_JUMP_EN
    logic signed [ADDR_W-1:0] w_rel_off;
    logic signed [ADDR_W-1:0] w_rel_sum;

    // Offset is already ADDR_W wide, so sign extension folds into the modular add.
    assign w_rel_off     = $signed(addr_in);
    assign w_rel_sum     = $signed(r_addr) + w_rel_off;
    assign w_load_target = rel ? $unsigned(w_rel_sum) : addr_in;
`else
    assign w_load_target = addr_in;
`endif

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_inc),
        .dout      (w_stack_top),
        .sp        (sp),
        .full      (full),
        .empty     (w_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= RESET_ADDR;
        end else begin
            case (w_cmd)
                CMD_RET: begin
                    if (!w_empty) begin
                        r_addr <= w_stack_top;
                    end
                end
                CMD_CALL:  r_addr <= addr_in;
                CMD_LOAD:  r_addr <= w_load_target;
                CMD_COUNT: r_addr <= w_inc;
                default:   r_addr <= r_addr;
            endcase
        end
    end

    assign addr_out = r_addr;
    assign empty    = w_empty;

endmodule
